barrett_precompute: RTL and testbench

- Sequential front end for barretReduce: from a modulus m it computes the modulus bit length k and the Barrett constant floor(4^k / m).
- barretReduce consumes both as its R and constant inputs.
- Sits in the top-level setup path; runs once per new candidate factor, so it is optimised for area (one quotient bit per clock), not throughput.

---
 rtl/barrett_precompute.sv | 124 ++++++++++++
 tb/tb_barrett_precompute.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/barrett_precompute.sv
// Sequential Barrett setup: from modulus m, finds bit length k and floor(4^k / m)
// using a priority encoder and a one-bit-per-clock restoring divider.
module barrett_precompute #(
  parameter int BITWIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BITWIDTH-1:0]   modulus,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [BITWIDTH-1:0]   R,
  output logic [BITWIDTH+1:0]   constant
);
  localparam int CW = $clog2(2*BITWIDTH+1);

  typedef enum logic [1:0] {IDLE, NORM, DIV, FIN} state_t;

  state_t                state_q, state_d;
  logic [BITWIDTH-1:0]   m_q, m_d;
  logic [BITWIDTH:0]     rem_q, rem_d;
  logic [BITWIDTH+1:0]   quo_q, quo_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BITWIDTH-1:0]   r_q, r_d;
  logic [BITWIDTH+1:0]   const_q, const_d;
  logic                  err_q, err_d;

  logic [BITWIDTH-1:0]   k;
  logic [CW-1:0]         two_k, two_k_r;
  logic [BITWIDTH:0]     rem_sh, rem_nx;
  logic [BITWIDTH+1:0]   quo_nx;
  logic                  ge;

  always_comb begin
    k = '0;
    for (int b = 0; b < BITWIDTH; b++)
      if (m_q[b]) k = BITWIDTH'(b + 1);
  end

  assign two_k   = CW'({k, 1'b0});
  assign two_k_r = CW'({r_q, 1'b0});

  // The dividend 2^(2k) contributes a single 1 on the first DIV iteration.
  assign rem_sh = (BITWIDTH+1)'({rem_q, (cnt_q == two_k_r)});
  assign ge     = rem_sh >= {1'b0, m_q};
  assign rem_nx = ge ? (rem_sh - {1'b0, m_q}) : rem_sh;
  assign quo_nx = (BITWIDTH+2)'({quo_q, ge});

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    const_d = const_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = modulus;
          state_d = NORM;
        end
      end
      NORM: begin
        if (m_q == '0) begin
          err_d   = 1'b1;
          r_d     = '0;
          const_d = '0;
          state_d = FIN;
        end else begin
          err_d   = 1'b0;
          r_d     = k;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = two_k;
          state_d = DIV;
        end
      end
      DIV: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        if (cnt_q == '0) begin
          // Load the final quotient on the way out so it is already valid with done.
          const_d = quo_nx;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
      const_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      const_q <= const_d;
      err_q   <= err_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);
  assign error    = err_q;
  assign R        = r_q;
  assign constant = const_q;
endmodule

// File: tb/tb_barrett_precompute.sv
// Scoreboard bench for barrett_precompute: expected results queued at start, checked at done.
module tb_barrett_precompute;
  localparam int BW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [BW-1:0] modulus;
  logic          busy, done, error;
  logic [BW-1:0] R;
  logic [BW+1:0] constant;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [BW-1:0] r;
    logic [BW+1:0] c;
    logic          err;
    int            lat;
  } exp_t;

  exp_t sb[$];

  barrett_precompute #(.BITWIDTH(BW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .modulus(modulus),
    .busy(busy), .done(done), .error(error), .R(R), .constant(constant)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [BW-1:0] m);
    exp_t e;
    int kk;
    logic [2*BW+1:0] dvd;
    logic [2*BW+1:0] q;
    kk = 0;
    for (int i = 0; i < BW; i++) if (m[i]) kk = i + 1;
    if (m == '0) begin
      e.r = '0; e.c = '0; e.err = 1'b1; e.lat = 2;
    end else begin
      dvd = '0;
      dvd[2*kk] = 1'b1;
      q = dvd / {{(BW+2){1'b0}}, m};
      e.r = BW'(kk); e.c = q[BW+1:0]; e.err = 1'b0; e.lat = 2*kk + 3;
    end
    return e;
  endfunction

  // One request; disturb injects a second start and modulus churn during DIV.
  task automatic do_op(input logic [BW-1:0] m, input bit disturb, input string name);
    exp_t e;
    int cyc;
    int seen_cyc;
    bit seen;
    bit busy_ok;
    e = model(m);
    sb.push_back(e);
    @(negedge clk);
    modulus = m;
    start   = 1'b1;
    @(posedge clk);
    cyc = 0; seen = 0; busy_ok = 1; seen_cyc = -1;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (busy !== (cyc <= e.lat)) busy_ok = 0;
      if (disturb && cyc == 4) begin start = 1'b1; modulus = 32'd5; end
      if (disturb && cyc == 5) begin start = 1'b0; modulus = 32'd9; end
      if (done === 1'b1) begin seen = 1; seen_cyc = cyc; end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s timeout: no done after %0d cycles", name, cyc);
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    total++;
    if (seen_cyc !== e.lat) begin
      bad++; $display("FAIL %s latency: got %0d want %0d", name, seen_cyc, e.lat);
    end
    total++;
    if (R !== e.r) begin
      bad++; $display("FAIL %s R: got %0d want %0d", name, R, e.r);
    end
    total++;
    if (constant !== e.c) begin
      bad++; $display("FAIL %s constant: got %h want %h", name, constant, e.c);
    end
    total++;
    if (error !== e.err) begin
      bad++; $display("FAIL %s error: got %b want %b", name, error, e.err);
    end
    total++;
    if (!busy_ok) begin
      bad++; $display("FAIL %s busy: profile wrong (got %b at end) want high cycles 1..%0d", name, busy, e.lat);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; modulus = '0;
    #1;
    total++;
    if ({busy, done, error, R, constant} !== '0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b err=%b R=%0d c=%h want all 0",
               busy, done, error, R, constant);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_op(32'd7,          0, "m7");
    do_op(32'd8,          0, "m8");
    do_op(32'd1,          0, "m1");
    do_op(32'hFFFF_FFFF,  0, "mmax");
    do_op(32'h8000_0000,  0, "mpow31");
    do_op(32'd0,          0, "m0");
    do_op(32'd7,          0, "m7_after_err");
  endtask

  task automatic test_ignored_start();
    bit extra;
    do_op(32'd7, 1, "ignored_start");
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra = 1;
    end
    total++;
    if (extra) begin
      bad++; $display("FAIL ignored_start extra_op: got activity after done want none");
    end
  endtask

  task automatic test_reset_mid();
    bit spurious;
    @(negedge clk);
    modulus = 32'hFFFF_FFFF;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, error, R, constant} !== '0) begin
      bad++;
      $display("FAIL reset_mid outputs: got busy=%b done=%b err=%b R=%0d c=%h want all 0",
               busy, done, error, R, constant);
    end
    spurious = 0;
    repeat (4) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) spurious = 1;
    end
    rst_n = 1'b1;
    repeat (70) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) spurious = 1;
    end
    total++;
    if (spurious) begin
      bad++; $display("FAIL reset_mid no_done: got done/busy after abort want none");
    end
    do_op(32'd13, 0, "m13_after_reset");
  endtask

  task automatic test_random();
    logic [BW-1:0] m;
    for (int n = 0; n < 1000; n++) begin
      m = $urandom() >> $urandom_range(0, 31);
      if (m == '0) m = 32'd1;
      do_op(m, 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
